// File: rtl/sys_bridge_timer.sv
// sys_bridge_timer: CPU-side I/O bridge. Decodes the processor bus onto a
// countdown timer (CTRL/PRESET/COUNT), a 32-bit output port and a 32-bit
// input port, and drives the CPU hardware interrupt lines HWInt[7:2].
module sys_bridge_timer #(
  parameter logic [31:0] BASE        = 32'h0000_7F00,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] PrAddr,
  input  logic [31:0] PrWD,
  input  logic [3:0]  BE,
  output logic [31:0] PrRD,
  output logic [7:2]  HWInt,
  input  logic [31:0] dev_in,
  output logic [31:0] dev_out,
  input  logic        dev_irq
);

  // Word addresses of the mapped registers.
  localparam logic [29:0] AddrCtrl   = BASE[31:2];
  localparam logic [29:0] AddrPreset = BASE[31:2] + 30'd1;
  localparam logic [29:0] AddrCount  = BASE[31:2] + 30'd2;
  localparam logic [29:0] AddrOut    = BASE[31:2] + 30'd4;
  localparam logic [29:0] AddrIn     = BASE[31:2] + 30'd5;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCnt,
    StInt
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic        r_en;
  logic [1:0]  r_mode;
  logic        r_im;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic [31:0] w_count_nxt;
  logic [31:0] r_out;
  logic        r_irq_flag;
  logic [SYNC_STAGES-1:0] r_sync;

  logic w_we;
  logic w_sel_ctrl;
  logic w_sel_preset;
  logic w_sel_count;
  logic w_sel_out;
  logic w_sel_in;
  logic w_irq_set;
  logic w_en_clr;

  // Only BE[1] acts as the write strobe.
  logic w_unused;
  assign w_unused = ^{BE[3:2], BE[0]};

  assign w_we         = BE[1];
  assign w_sel_ctrl   = (PrAddr == AddrCtrl);
  assign w_sel_preset = (PrAddr == AddrPreset);
  assign w_sel_count  = (PrAddr == AddrCount);
  assign w_sel_out    = (PrAddr == AddrOut);
  assign w_sel_in     = (PrAddr == AddrIn);

  // Timer next-state, count update and interrupt/enable-clear strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_irq_set   = 1'b0;
    w_en_clr    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_en) w_state_nxt = StLoad;
      end
      StLoad: begin
        w_count_nxt = r_preset;
        w_state_nxt = StCnt;
      end
      StCnt: begin
        if (!r_en) begin
          w_state_nxt = StIdle;
        end else if (r_count == 32'd0) begin
          w_state_nxt = StInt;
          w_irq_set   = 1'b1;
        end else begin
          w_count_nxt = r_count - 32'd1;
        end
      end
      StInt: begin
        // Only MODE 01 reloads; 00, 10 and 11 are all one-shot.
        if (r_mode == 2'b01) begin
          w_state_nxt = StLoad;
        end else begin
          w_en_clr    = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Timer state and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_count <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // CTRL register; a CPU write takes priority over the one-shot EN clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en   <= 1'b0;
      r_mode <= 2'b00;
      r_im   <= 1'b0;
    end else if (w_we && w_sel_ctrl) begin
      r_en   <= PrWD[0];
      r_mode <= PrWD[2:1];
      r_im   <= PrWD[3];
    end else if (w_en_clr) begin
      r_en <= 1'b0;
    end
  end

  // PRESET and OUT data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_preset <= 32'd0;
      r_out    <= 32'd0;
    end else begin
      if (w_we && w_sel_preset) r_preset <= PrWD;
      if (w_we && w_sel_out)    r_out    <= PrWD;
    end
  end

  // Interrupt flag: set beats a simultaneous clear by a CTRL/PRESET write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_flag <= 1'b0;
    end else if (w_irq_set) begin
      r_irq_flag <= 1'b1;
    end else if (w_we && (w_sel_ctrl || w_sel_preset)) begin
      r_irq_flag <= 1'b0;
    end
  end

  // Synchroniser chain for the asynchronous external interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], dev_irq};
    end
  end

  // Combinational read mux; unmapped addresses read as zero.
  always_comb begin
    PrRD = 32'd0;
    if (w_sel_ctrl) begin
      PrRD = {28'd0, r_im, r_mode, r_en};
    end else if (w_sel_preset) begin
      PrRD = r_preset;
    end else if (w_sel_count) begin
      PrRD = r_count;
    end else if (w_sel_out) begin
      PrRD = r_out;
    end else if (w_sel_in) begin
      PrRD = dev_in;
    end
  end

  assign dev_out    = r_out;
  assign HWInt[2]   = r_irq_flag & r_im;
  assign HWInt[3]   = r_sync[SYNC_STAGES-1];
  assign HWInt[7:4] = 4'd0;

endmodule

// File: tb/tb_sys_bridge_timer.sv
// Testbench for sys_bridge_timer: a decode vector table, directed timer
// sequences and randomized timer episodes checked against an arithmetic model.
module tb_sys_bridge_timer;

  localparam logic [31:0] Base = 32'h0000_7F00;
  localparam int unsigned Sync = 2;
  localparam logic [11:0] OffCtrl = 12'h000;
  localparam logic [11:0] OffPre  = 12'h004;
  localparam logic [11:0] OffCnt  = 12'h008;
  localparam logic [11:0] OffOut  = 12'h010;
  localparam logic [11:0] OffIn   = 12'h014;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] PrAddr;
  logic [31:0] PrWD;
  logic [3:0]  BE;
  logic [31:0] PrRD;
  logic [7:2]  HWInt;
  logic [31:0] dev_in;
  logic [31:0] dev_out;
  logic        dev_irq;

  sys_bridge_timer #(
    .BASE       (Base),
    .SYNC_STAGES(Sync)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .PrAddr (PrAddr),
    .PrWD   (PrWD),
    .BE     (BE),
    .PrRD   (PrRD),
    .HWInt  (HWInt),
    .dev_in (dev_in),
    .dev_out(dev_out),
    .dev_irq(dev_irq)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // dev_irq values sampled at the last Sync edges; [0] is what HWInt[3] shows.
  logic irq_q[$];

  typedef struct packed {
    logic [11:0] off;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] din;
    logic [31:0] exp_rd;
    logic [31:0] exp_out;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [29:0] wa(input logic [11:0] off);
    logic [31:0] a;
    a = Base + {20'd0, off};
    return a[31:2];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Advance one rising edge and return 1 time unit after it.
  task automatic tick();
    logic s;
    s = dev_irq;
    @(posedge clk);
    #1;
    irq_q.push_back(s);
    irq_q.delete(0);
  endtask

  // Called 1 unit after an edge; reset pulse stays clear of the next edge.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    irq_q.delete();
    for (int i = 0; i < Sync; i++) irq_q.push_back(1'b0);
  endtask

  task automatic bus_wr(input logic [11:0] off, input logic [31:0] d);
    PrAddr = wa(off);
    PrWD   = d;
    BE     = 4'b0010;
  endtask

  task automatic bus_rd(input logic [11:0] off);
    PrAddr = wa(off);
    PrWD   = 32'h0;
    BE     = 4'b0000;
  endtask

  task automatic bus_idle();
    bus_rd(12'h040);
  endtask

  // COUNT value s edges after the EN-setting edge, timer with preset n.
  function automatic logic [31:0] cnt_at(input int n, input bit auto_m, input int s);
    int q;
    if (s < 2) return 32'd0;
    q = s - 2;
    if (auto_m) q = q % (n + 3);
    return (q <= n) ? 32'(n - q) : 32'd0;
  endfunction

  task automatic episode();
    int          n;
    int          k;
    int          op;
    int          s;
    bit          auto_m;
    bit          im;
    bit          flag;
    bit          clr;
    bit          do_rd;
    bit          set;
    logic [1:0]  mode;
    logic [31:0] ctrl_v;
    logic [31:0] m_out;
    logic [31:0] w;
    logic [31:0] exp;
    logic [11:0] uoff[5];
    uoff[0] = 12'h00C; uoff[1] = 12'h018; uoff[2] = 12'h01C;
    uoff[3] = 12'h020; uoff[4] = 12'h100;
    do_reset();
    m_out  = 32'd0;
    flag   = 1'b0;
    n      = int'($urandom_range(0, 6));
    auto_m = 1'($urandom_range(0, 1));
    im     = ($urandom_range(0, 3) != 0);
    if (auto_m) mode = 2'b01;
    else if ($urandom_range(0, 2) == 0) mode = 2'b00;
    else mode = $urandom_range(0, 1) ? 2'b10 : 2'b11;
    ctrl_v = {28'd0, im, mode, 1'b1};
    bus_wr(OffPre, 32'(n));
    tick();
    bus_wr(OffCtrl, ctrl_v);
    #1 chk("ep_ctrl_before_start", PrRD, 32'd0);
    tick();
    k = 3 * (n + 3) + 2;
    for (int t = 1; t <= k; t++) begin
      s       = t - 1;
      clr     = 1'b0;
      do_rd   = 1'b1;
      exp     = 32'd0;
      w       = 32'd0;
      dev_irq = 1'($urandom_range(0, 1));
      op      = int'($urandom_range(0, 7));
      case (op)
        0: begin bus_rd(OffCnt); exp = cnt_at(n, auto_m, s); end
        1: begin
          bus_rd(OffCtrl);
          exp = {28'd0, im, mode, (auto_m || s < n + 4)};
        end
        2: begin dev_in = $urandom; bus_rd(OffIn); exp = dev_in; end
        3: begin w = $urandom; bus_wr(OffOut, w); exp = m_out; end
        4: begin
          case ($urandom_range(0, 2))
            0: bus_wr(OffCtrl, $urandom);
            1: bus_wr(OffPre, $urandom);
            default: bus_wr(OffOut, $urandom);
          endcase
          BE    = 4'($urandom) & 4'b1101;
          do_rd = 1'b0;
        end
        5: begin
          if ($urandom_range(0, 1) == 1) bus_wr(uoff[$urandom_range(0, 4)], $urandom);
          else bus_rd(uoff[$urandom_range(0, 4)]);
          exp = 32'd0;
        end
        6: begin
          if (auto_m) begin
            bus_wr(OffCtrl, ctrl_v | ($urandom & 32'hFFFF_FFF0));
            clr = 1'b1;
            exp = ctrl_v;
          end else begin
            bus_wr(OffCnt, $urandom);
            exp = cnt_at(n, auto_m, s);
          end
        end
        default: begin bus_rd(OffPre); exp = 32'(n); end
      endcase
      #1;
      if (do_rd) chk("ep_read", PrRD, exp);
      tick();
      if (op == 3) m_out = w;
      set = auto_m ? (t % (n + 3) == 0) : (t == n + 3);
      if (set) flag = 1'b1;
      else if (clr) flag = 1'b0;
      chk("ep_hwint2", {31'd0, HWInt[2]}, {31'd0, flag & im});
      chk("ep_hwint3", {31'd0, HWInt[3]}, {31'd0, irq_q[0]});
      chk("ep_hwint_hi", {28'd0, HWInt[7:4]}, 32'd0);
      chk("ep_dev_out", dev_out, m_out);
    end
    dev_irq = 1'b0;
    bus_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    PrAddr  = wa(12'h040);
    PrWD    = 32'd0;
    BE      = 4'd0;
    dev_in  = 32'h1357_9BDF;
    dev_irq = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Reset state.
    chk("rst_hwint", {26'd0, HWInt}, 32'd0);
    chk("rst_dev_out", dev_out, 32'd0);
    bus_rd(OffIn);  #1 chk("rst_rd_in", PrRD, 32'h1357_9BDF);
    bus_rd(OffCtrl); #1 chk("rst_rd_ctrl", PrRD, 32'd0);
    bus_rd(OffCnt);  #1 chk("rst_rd_count", PrRD, 32'd0);
    bus_idle();
    tick();

    // Decode table: PrRD is checked before the edge (old value on a write).
    tbl[0]  = '{OffOut, 4'h2, 32'hDEADBEEF, 32'h0, 32'h0, 32'hDEADBEEF};
    tbl[1]  = '{OffOut, 4'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2]  = '{OffPre, 4'hF, 32'h12345678, 32'h0, 32'h0, 32'hDEADBEEF};
    tbl[3]  = '{OffPre, 4'h0, 32'h0, 32'h0, 32'h12345678, 32'hDEADBEEF};
    tbl[4]  = '{OffCtrl, 4'h2, 32'hFFFFFFF6, 32'h0, 32'h0, 32'hDEADBEEF};
    tbl[5]  = '{OffCtrl, 4'h0, 32'h0, 32'h0, 32'h6, 32'hDEADBEEF};
    tbl[6]  = '{OffCnt, 4'h2, 32'hAAAA5555, 32'h0, 32'h0, 32'hDEADBEEF};
    tbl[7]  = '{OffCnt, 4'h0, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF};
    tbl[8]  = '{OffOut, 4'hD, 32'h11111111, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[9]  = '{OffPre, 4'hD, 32'hFFFF0000, 32'h0, 32'h12345678, 32'hDEADBEEF};
    tbl[10] = '{OffPre, 4'h0, 32'h0, 32'h0, 32'h12345678, 32'hDEADBEEF};
    tbl[11] = '{OffIn, 4'h0, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 32'hDEADBEEF};
    tbl[12] = '{12'h020, 4'h0, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF};
    tbl[13] = '{12'h020, 4'h2, 32'h77777777, 32'h0, 32'h0, 32'hDEADBEEF};
    tbl[14] = '{OffIn, 4'h2, 32'h5, 32'h0BADF00D, 32'h0BADF00D, 32'hDEADBEEF};
    tbl[15] = '{OffOut, 4'h2, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
    for (int i = 0; i < 16; i++) begin
      PrAddr = wa(tbl[i].off);
      BE     = tbl[i].be;
      PrWD   = tbl[i].wd;
      dev_in = tbl[i].din;
      #1 chk($sformatf("tbl%0d_rd", i), PrRD, tbl[i].exp_rd);
      tick();
      chk($sformatf("tbl%0d_out", i), dev_out, tbl[i].exp_out);
    end
    bus_idle();

    // One-shot: PRESET=5, CTRL=0x9 at e0 -> IRQ after e8, EN clear after e9.
    do_reset();
    bus_wr(OffPre, 32'd5); tick();
    bus_wr(OffCtrl, 32'h9); tick();
    for (int t = 1; t <= 10; t++) begin
      bus_idle();
      if (t == 7) begin bus_rd(OffCnt); #1 chk("os_count_e6", PrRD, 32'd1); end
      if (t == 8) begin bus_rd(OffCnt); #1 chk("os_count_e7", PrRD, 32'd0); end
      if (t == 9) begin bus_rd(OffCtrl); #1 chk("os_ctrl_e8", PrRD, 32'h9); end
      if (t == 10) begin bus_rd(OffCtrl); #1 chk("os_ctrl_e9", PrRD, 32'h8); end
      tick();
      if (t == 7) chk("os_hw2_e7", {31'd0, HWInt[2]}, 32'd0);
      if (t >= 8) chk("os_hw2_hold", {31'd0, HWInt[2]}, 32'd1);
    end
    bus_wr(OffCtrl, 32'h8); tick();
    chk("os_hw2_cleared", {31'd0, HWInt[2]}, 32'd0);

    // Auto-reload: PRESET=3, CTRL=0xB -> flag every 6 edges; clears at e8, e14.
    do_reset();
    bus_wr(OffPre, 32'd3); tick();
    bus_wr(OffCtrl, 32'hB); tick();
    begin
      logic [19:0] exp_hw2;
      exp_hw2 = 20'hC30C0;
      for (int t = 1; t <= 19; t++) begin
        if (t == 8 || t == 14) bus_wr(OffCtrl, 32'hB);
        else bus_idle();
        tick();
        chk($sformatf("ar_hw2_e%0d", t), {31'd0, HWInt[2]}, {31'd0, exp_hw2[t]});
      end
    end

    // Masking: PRESET=0, IM=0 auto; setting IM on a set edge raises HWInt[2].
    do_reset();
    bus_wr(OffPre, 32'd0); tick();
    bus_wr(OffCtrl, 32'h3); tick();
    for (int t = 1; t <= 6; t++) begin
      if (t == 6) bus_wr(OffCtrl, 32'hB);
      else bus_idle();
      tick();
      chk($sformatf("mask_hw2_e%0d", t), {31'd0, HWInt[2]}, (t == 6) ? 32'd1 : 32'd0);
    end

    // PRESET rewritten mid-count leaves the current period alone.
    do_reset();
    bus_wr(OffPre, 32'd5); tick();
    bus_wr(OffCtrl, 32'hB); tick();
    for (int t = 1; t <= 12; t++) begin
      bus_idle();
      if (t == 4) bus_wr(OffPre, 32'd2);
      if (t == 7) begin bus_rd(OffCnt); #1 chk("mp_count_e6", PrRD, 32'd1); end
      if (t == 11) begin bus_rd(OffCnt); #1 chk("mp_count_e10", PrRD, 32'd2); end
      if (t == 12) begin bus_rd(OffCnt); #1 chk("mp_count_e11", PrRD, 32'd1); end
      tick();
      if (t == 7) chk("mp_hw2_e7", {31'd0, HWInt[2]}, 32'd0);
      if (t == 8) chk("mp_hw2_e8", {31'd0, HWInt[2]}, 32'd1);
    end

    // Reset mid-count with the flag set.
    do_reset();
    bus_wr(OffOut, 32'h55); tick();
    bus_wr(OffPre, 32'd2); tick();
    bus_wr(OffCtrl, 32'hB); tick();
    bus_idle();
    for (int t = 1; t <= 7; t++) tick();
    chk("rm_hw2_before", {31'd0, HWInt[2]}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rm_hwint", {26'd0, HWInt}, 32'd0);
    chk("rm_dev_out", dev_out, 32'd0);
    bus_rd(OffCtrl); #1 chk("rm_rd_ctrl", PrRD, 32'd0);
    bus_rd(OffPre);  #1 chk("rm_rd_preset", PrRD, 32'd0);
    bus_rd(OffCnt);  #1 chk("rm_rd_count", PrRD, 32'd0);
    rst = 1'b0;
    bus_idle();
    irq_q.delete();
    for (int i = 0; i < Sync; i++) irq_q.push_back(1'b0);
    for (int t = 1; t <= 8; t++) begin
      tick();
      chk("rm_no_irq", {26'd0, HWInt}, 32'd0);
    end

    // External IRQ: 3-cycle pulse shows on HWInt[3] 2 edges later.
    do_reset();
    bus_idle();
    tick();
    for (int t = 1; t <= 6; t++) begin
      dev_irq = (t <= 3);
      tick();
      chk($sformatf("xirq_e%0d", t), {31'd0, HWInt[3]}, {31'd0, (t >= 2 && t <= 4)});
      chk("xirq_hi", {28'd0, HWInt[7:4]}, 32'd0);
    end
    dev_irq = 1'b0;

    // Randomized timer episodes.
    for (int e = 0; e < 12; e++) episode();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
